// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, requester-id width helper and latency counter width for the lookup arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int LAT_W = 4;
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: rotating-priority picker; req/ptr in, found/idx out (first set req at or above ptr, wrapping)
module mem_arb_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        idx = ID_W'((int'(ptr) + i) % N_REQ);
      end
  end
endmodule

// File: rtl/mem_lookup_arbiter.sv
// mem_lookup_arbiter: round-robin sharing of one memory lookup port; req/req_addr in, gnt out, mem_addr/mem_valid/mem_v_err to memory, rsp_valid/rsp_id/rsp_err/err_count out
module mem_lookup_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 8,
  parameter int MEM_LAT = 0,
  parameter int ERR_CNT_W = 16,
  localparam int ID_W = id_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_valid,
  input  logic                    mem_v_err,
  output logic [ERR_CNT_W-1:0]    err_count
);
  state_t state, state_d;
  logic [ID_W-1:0] ptr, k, pick;
  logic [LAT_W-1:0] cnt;
  logic found, take, sample;
  mem_arb_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req(req), .ptr(ptr), .found(found), .idx(pick)
  );
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_d;
  always_comb
    state_d = state == IDLE  ? (found ? ISSUE : IDLE) :
              state == ISSUE ? (MEM_LAT == 0 ? RESP : WAIT) :
              state == WAIT  ? (cnt == '0 ? RESP : WAIT) : IDLE;
  always_comb begin
    take = state == IDLE && found;
    sample = (state == ISSUE && MEM_LAT == 0) || (state == WAIT && cnt == '0);
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      ptr <= '0;
      k <= '0;
      cnt <= '0;
      gnt <= '0;
      mem_valid <= 1'b0;
      mem_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_err <= 1'b0;
      err_count <= '0;
    end else begin
      gnt <= take ? N_REQ'(1) << pick : '0;
      mem_valid <= take;
      rsp_valid <= sample;
      if (take) begin
        k <= pick;
        mem_addr <= req_addr[pick*ADDR_W +: ADDR_W];
      end
      if (state == ISSUE) cnt <= LAT_W'(MEM_LAT - 1);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (sample) begin
        rsp_id <= k;
        rsp_err <= mem_v_err;
        if (mem_v_err && err_count != '1) err_count <= err_count + 1'b1;
      end
      if (state == RESP) ptr <= k == ID_W'(N_REQ - 1) ? '0 : k + 1'b1;
    end
endmodule

// File: tb/tb_mem_lookup_arbiter.sv
// tb_mem_lookup_arbiter: scoreboard bench for two arbiter instances (MEM_LAT=0 with 2-bit counter, MEM_LAT=3)
module tb_mem_lookup_arbiter;
  localparam int N = 4, AW = 8;
  typedef struct {logic [N-1:0] gnt; logic [AW-1:0] addr;} g_t;
  typedef struct {logic [1:0] id; logic err; logic [15:0] cnt;} r_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req [2], gnt [2];
  logic [N*AW-1:0] req_addr [2];
  logic [AW-1:0] mem_addr [2];
  logic mem_valid [2], mem_v_err [2], rsp_valid [2], rsp_err [2];
  logic [1:0] rsp_id [2];
  logic [1:0] ec0;
  logic [15:0] ec1;
  logic [15:0] err_count [2];
  logic [2:0] dly = '0;
  logic sel3 = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int mv_cyc [2] = '{0, 0};
  int lat [2] = '{1, 4};
  logic last_mv [2] = '{1'b0, 1'b0};
  g_t gq [2][$];
  r_t rq [2][$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mem_lookup_arbiter #(.N_REQ(N), .ADDR_W(AW), .MEM_LAT(0), .ERR_CNT_W(2)) u0 (
    .clk(clk), .reset_n(reset_n), .req(req[0]), .req_addr(req_addr[0]), .gnt(gnt[0]),
    .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_err(rsp_err[0]), .mem_addr(mem_addr[0]),
    .mem_valid(mem_valid[0]), .mem_v_err(mem_v_err[0]), .err_count(ec0)
  );
  mem_lookup_arbiter #(.N_REQ(N), .ADDR_W(AW), .MEM_LAT(3), .ERR_CNT_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .req(req[1]), .req_addr(req_addr[1]), .gnt(gnt[1]),
    .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_err(rsp_err[1]), .mem_addr(mem_addr[1]),
    .mem_valid(mem_valid[1]), .mem_v_err(mem_v_err[1]), .err_count(ec1)
  );
  assign err_count[0] = {14'b0, ec0};
  assign err_count[1] = ec1;
  assign mem_v_err[0] = mem_valid[0] & mem_addr[0][7];
  always @(posedge clk) dly <= {dly[1:0], mem_valid[1]};
  assign mem_v_err[1] = sel3 ? dly[2] : dly[1];
  task automatic chk(input int d, input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0h expected %0h", d, n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    g_t g;
    r_t r;
    for (int d = 0; d < 2; d++)
      if (!reset_n) last_mv[d] = 1'b0;
      else begin
        if (mem_valid[d] && last_mv[d]) chk(d, "mem_valid_back_to_back", last_mv[d], 0);
        if (gnt[d] != '0 && !mem_valid[d]) chk(d, "gnt_without_valid", gnt[d], 0);
        if (mem_valid[d]) begin
          mv_cyc[d] = cyc;
          chk(d, "issue_expected", gq[d].size() > 0, 1);
          if (gq[d].size() > 0) begin
            g = gq[d].pop_front();
            chk(d, "gnt", gnt[d], g.gnt);
            chk(d, "mem_addr", mem_addr[d], g.addr);
          end
        end
        if (rsp_valid[d]) begin
          chk(d, "rsp_expected", rq[d].size() > 0, 1);
          if (rq[d].size() > 0) begin
            r = rq[d].pop_front();
            chk(d, "rsp_id", rsp_id[d], r.id);
            chk(d, "rsp_err", rsp_err[d], r.err);
            chk(d, "err_count", err_count[d], r.cnt);
            chk(d, "rsp_latency", cyc - mv_cyc[d], lat[d]);
          end
        end
        last_mv[d] = mem_valid[d];
      end
  end
  task automatic expect_lookup(input int d, input int idx, input logic [7:0] a, input logic err, input logic [15:0] cnt);
    gq[d].push_back('{gnt: 4'b0001 << idx, addr: a});
    rq[d].push_back('{id: 2'(idx), err: err, cnt: cnt});
  endtask
  task automatic wait_gnt(input int d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt[d] == '0 && n < 20);
  endtask
  task automatic wait_rsp(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[d] && n < 30);
    chk(d, "rsp_seen", rsp_valid[d], 1);
  endtask
  task automatic lookup(input int d, input logic [N-1:0] r, input logic [N*AW-1:0] a);
    int n;
    @(negedge clk);
    req[d] = r;
    req_addr[d] = a;
    wait_gnt(d, n);
    chk(d, "gnt_latency", n, 1);
    req[d] = '0;
    wait_rsp(d);
  endtask
  initial begin
    int n;
    int t [5];
    for (int d = 0; d < 2; d++) begin
      req[d] = '0;
      req_addr[d] = '0;
    end
    repeat (2) @(negedge clk);
    chk(0, "reset_gnt", gnt[0], 0);
    chk(0, "reset_mem_valid", mem_valid[0], 0);
    chk(0, "reset_rsp_valid", rsp_valid[0], 0);
    chk(0, "reset_mem_addr", mem_addr[0], 0);
    chk(0, "reset_rsp_id", rsp_id[0], 0);
    chk(0, "reset_rsp_err", rsp_err[0], 0);
    chk(0, "reset_err_count", err_count[0], 0);
    chk(1, "reset_err_count", err_count[1], 0);
    reset_n = 1'b1;
    expect_lookup(0, 0, 8'h01, 1'b0, 0);
    lookup(0, 4'b0001, 32'h0000_0001);
    expect_lookup(0, 2, 8'hFF, 1'b1, 1);
    lookup(0, 4'b0100, 32'h00FF_0000);
    expect_lookup(0, 3, 8'h80, 1'b1, 2);
    lookup(0, 4'b1000, 32'h8000_0000);
    for (int i = 0; i < 5; i++) expect_lookup(0, i % 4, 8'h10 + 8'h11 * 8'(i % 4), 1'b0, 2);
    @(negedge clk);
    req[0] = 4'b1111;
    req_addr[0] = 32'h4332_2110;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(0, n);
      chk(0, "fair_gnt_seen", gnt[0] != '0, 1);
      t[i] = cyc;
      if (i > 0) chk(0, "fair_spacing", t[i] - t[i-1], 3);
    end
    req[0] = '0;
    wait_rsp(0);
    expect_lookup(0, 1, 8'h9A, 1'b1, 3);
    lookup(0, 4'b0010, 32'h0000_9A00);
    expect_lookup(0, 1, 8'hC3, 1'b1, 3);
    lookup(0, 4'b0010, 32'h0000_C300);
    @(negedge clk);
    chk(0, "err_count_saturated", err_count[0], 3);
    sel3 = 1'b1;
    expect_lookup(1, 1, 8'h05, 1'b1, 1);
    lookup(1, 4'b0010, 32'h0000_0500);
    sel3 = 1'b0;
    expect_lookup(1, 1, 8'h06, 1'b0, 1);
    lookup(1, 4'b0010, 32'h0000_0600);
    sel3 = 1'b1;
    gq[1].push_back('{gnt: 4'b1000, addr: 8'h07});
    @(negedge clk);
    req[1] = 4'b1000;
    req_addr[1] = 32'h0700_0000;
    wait_gnt(1, n);
    chk(1, "gnt_latency", n, 1);
    req[1] = '0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk(1, "abort_err_count", err_count[1], 0);
    chk(1, "abort_rsp_valid", rsp_valid[1], 0);
    repeat (6) @(negedge clk);
    sel3 = 1'b0;
    expect_lookup(1, 1, 8'h11, 1'b0, 0);
    lookup(1, 4'b0110, 32'h0022_1100);
    repeat (3) @(negedge clk);
    chk(0, "queues_drained", gq[0].size() + rq[0].size() + gq[1].size() + rq[1].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_lookup_arbiter.md
Name: mem_lookup_arbiter

Overview:
- Shares the single address-lookup port of memory_module (addr, valid, v_err) between N_REQ requesters.
- Picks requesters round-robin and issues one lookup at a time, exactly one valid pulse per transaction.
- Samples v_err after a fixed latency and returns a tagged response to the requester.
- Keeps a saturating count of failed lookups (address not present) for status/debug.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADDR_W, 8, memory address width; matches memory_module addr.
- MEM_LAT, 0, cycles from the valid cycle to the cycle v_err is meaningful (0..15); 0 means v_err is valid in the same cycle as valid.
- ERR_CNT_W, 16, width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- req  in  N_REQ  per-requester lookup request; held with req_addr until gnt.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  1  one-cycle pulse: lookup complete.
- rsp_id  out  ID_W  index of the responding requester; ID_W = max(1, clog2(N_REQ)).
- rsp_err  out  1  registered copy of v_err for this lookup; valid only with rsp_valid.
- mem_addr  out  ADDR_W  to memory_module addr.
- mem_valid  out  1  to memory_module valid.
- mem_v_err  in  1  from memory_module v_err.
- err_count  out  ERR_CNT_W  saturating count of rsp_err=1 responses.

Behaviour:
- Reset: synchronous, active-low. While reset_n=0 at a rising edge:
  - state goes to IDLE and the rr pointer to 0.
  - gnt, rsp_valid, rsp_err, mem_valid, mem_addr, rsp_id and err_count are all cleared to 0.
  - An in-flight transaction is dropped with no response.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM:
  - IDLE: if any req bit is set, pick index k by round-robin, latch req_addr[k] and k, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_valid=1, mem_addr=latched address, gnt[k]=1. If MEM_LAT=0, register mem_v_err and go to RESP. Otherwise go to WAIT.
  - WAIT: a down-counter is loaded with MEM_LAT-1 on entry. When it reaches 0, register mem_v_err and go to RESP.
  - RESP (1 cycle): rsp_valid=1, rsp_id=k, rsp_err=sampled value. If rsp_err=1, increment err_count. Set ptr=(k+1) mod N_REQ. Go to IDLE.
- Round-robin: search starts at ptr and goes upward, wrapping at N_REQ-1 to 0. The first set req bit wins. With a single requester active, it is granted every transaction.
- Timing, with req sampled in an IDLE cycle t:
  - gnt and mem_valid are high in cycle t+1.
  - rsp_valid is high in cycle t+2+MEM_LAT.
  - IDLE is re-entered in cycle t+3+MEM_LAT.
  - Peak throughput is one lookup per MEM_LAT+3 cycles.
- Handshake:
  - A requester holds req and req_addr stable until it sees gnt.
  - A req still asserted when IDLE is re-entered starts a new transaction.
  - req changes outside IDLE are ignored.
- mem_valid:
  - Is never high for two consecutive cycles.
  - Is high only in ISSUE.
  - mem_addr holds its last issued value between lookups.
- err_count saturates at all-ones and does not wrap.
- Reset asserted in ISSUE, WAIT or RESP aborts the transaction. No rsp_valid is issued for it and the requester must re-request.
- mem_v_err is ignored in every cycle except the sampling cycle.

Decomposition:
- mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP).
  - the ID_W computation function.
  - the MEM_LAT counter width constant (4 bits).
- Sub-module mem_arb_rr_pick: combinational rotating priority picker.
  - Inputs: req and ptr.
  - Outputs: found and idx.
  - Instantiated once.

Test Plan:
- Single request: reset 2 cycles; req=4'b0001, req_addr[0]=8'h01, MEM_LAT=0, mem_v_err=0 -> gnt=4'b0001 and mem_valid=1 with mem_addr=8'h01 exactly one cycle later; rsp_valid next cycle with rsp_id=0, rsp_err=0; err_count=0.
- Error path: req[2] with addr 8'hFF, memory model drives v_err=1 in the valid cycle -> rsp_id=2, rsp_err=1, err_count=1.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0; each gnt one-hot; mem_valid pulses spaced MEM_LAT+3 cycles apart.
- Latency: MEM_LAT=3, v_err pulsed only at valid+3 -> rsp_err=1. Repeat with v_err pulsed only at valid+2 -> rsp_err=0; rsp_valid at valid+4.
- Reset mid-operation: reset_n=0 for one cycle during WAIT -> no rsp_valid; err_count=0; ptr=0; next req=4'b0110 is granted to index 1.
- Saturation: ERR_CNT_W=2, four failing lookups -> err_count=3 after the 3rd and stays 3 after the 4th.
